// File: rtl/rpn_pkg.sv
// rpn_pkg: key codes and keypad FSM states shared by the keypad front end and the stack stage.
package rpn_pkg;
  localparam logic [4:0] PLUS  = 5'b10000;
  localparam logic [4:0] MINUS = 5'b10001;
  localparam logic [4:0] BACKS = 5'b10010;
  localparam logic [4:0] ENTER = 5'b10011;
  localparam logic [4:0] UP    = 5'b10100;
  localparam logic [4:0] DOWN  = 5'b10101;
  localparam logic [4:0] NOP   = 5'b10110;
  typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, HELD, RELEASE} kp_state_t;
  function automatic logic [4:0] encode_key(input logic [4:0] k);
    return k < 5'd10 ? k :
           k == 5'd10 ? PLUS :
           k == 5'd11 ? MINUS :
           k == 5'd12 ? BACKS :
           k == 5'd13 ? ENTER :
           k == 5'd14 ? UP :
           k == 5'd15 ? DOWN : NOP;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterized two-flop synchronizer.
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x5 matrix scan, debounce and key encoding for the RPN stack.
// Define KEYPAD_AUTOREPEAT_EN to add hold-to-repeat pulses in HELD.
module keypad_scanner
  import rpn_pkg::*;
#(
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE_CNT  = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [4:0] col_out,
  output logic [4:0] key_code,
  output logic       key_valid
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  kp_state_t   state;
  logic [2:0]  col, col_nxt;
  logic [1:0]  row, hi, low_idx;
  logic [SW-1:0] div;
  logic [DW-1:0] deb;
  logic [3:0]  row_s;
  logic        row_low, any_low, deb_done;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  logic [HW-1:0] hold;
  logic          rep;
`endif
  sync_2ff #(.W(4), .RST_VAL(4'hf)) u_sync (.clk(clk), .rst_n(rst_n), .d(row_in), .q(row_s));
  assign row_low  = !row_s[row];
  assign any_low  = !(&row_s);
  assign low_idx  = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
  assign col_nxt  = col == 3'd4 ? 3'd0 : col + 3'd1;
  assign deb_done = deb == DW'(DEBOUNCE_CNT - 1);
  assign col_out  = ~(5'd1 << col);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= '0;
      row       <= '0;
      hi        <= '0;
      div       <= '0;
      deb       <= '0;
      key_code  <= NOP;
      key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold      <= '0;
      rep       <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN:
          if (div == SW'(SCAN_DIV - 1)) begin
            div <= '0;
            if (any_low) begin
              row   <= low_idx;
              deb   <= '0;
              hi    <= '0;
              state <= DEBOUNCE;
            end else col <= col_nxt;
          end else div <= div + 1'b1;
        DEBOUNCE:
          if (row_low) begin
            hi  <= '0;
            deb <= deb + 1'b1;
            if (deb_done) begin
              key_code  <= encode_key({3'b0, row} * 5'd5 + {2'b0, col});
              key_valid <= 1'b1;
              state     <= PRESS;
            end
          end else begin
            deb <= '0;
            hi  <= hi + 1'b1;
            if (hi == 2'd3) begin
              col   <= col_nxt;
              state <= SCAN;
            end
          end
        PRESS: begin
          deb   <= '0;
          state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          hold  <= '0;
          rep   <= 1'b0;
`endif
        end
        HELD:
          if (row_low) begin
            deb <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            // first repeat lands REPEAT_DELAY cycles after the PRESS cycle, later ones every REPEAT_PERIOD
            if (hold == (rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 2))) begin
              key_valid <= 1'b1;
              hold      <= '0;
              rep       <= 1'b1;
            end else hold <= hold + 1'b1;
`endif
          end else begin
            deb <= deb + 1'b1;
            if (deb_done) state <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold <= '0;
            rep  <= 1'b0;
`endif
          end
        RELEASE: begin
          col   <= col_nxt;
          state <= SCAN;
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, encoding, reset and auto-repeat.
module tb_keypad_scanner;
  import rpn_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row_in;
  logic [4:0] col_out, key_code;
  logic key_valid;
  logic [19:0] keys = '0;
  int cyc = 0, npulse = 0, tests = 0, fails = 0;
  int tp[16];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DELAY(40), .REPEAT_PERIOD(20)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      if (npulse < 16) tp[npulse] = cyc;
      npulse++;
    end
  end

  // key matrix: a pressed key pulls its row low only while its column is driven
  always_comb begin
    row_in = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input int c, input string tag);
    logic [4:0] t, p;
    int k;
    t = ~(5'd1 << c);
    p = col_out;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (col_out == t && p != t) break;
      p = col_out;
    end
    chk(tag, k < 60, 1);
  endtask

  initial begin
    logic [4:0] ec;
    int m;
    cycles(3);
    chk("rst_col", col_out, 5'b11110);
    chk("rst_code", key_code, NOP);
    chk("rst_valid", key_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ec = ~(5'd1 << ((i / 4) % 5));
      chk("idle_col", col_out, ec);
      cycles(1);
    end
    chk("idle_pulses", npulse, 0);
    chk("idle_code", key_code, NOP);

    wait_col(3, "wait_col3");
    keys[8] = 1'b1;
    m = cyc;
    cycles(30);
    chk("k8_count", npulse, 1);
    chk("k8_code", key_code, 5'd8);
    chk("k8_latency", tp[0] - m, 12);
    keys[8] = 1'b0;
    cycles(40);
    chk("k8_rel_code", key_code, 5'd8);
    chk("k8_rel_count", npulse, 1);

    wait_col(0, "wait_col0_bounce");
    for (int i = 0; i < 5; i++) begin
      keys[10] = 1'b1;
      cycles(3);
      keys[10] = 1'b0;
      cycles(3);
    end
    chk("bounce_quiet", npulse, 1);
    keys[10] = 1'b1;
    m = cyc;
    cycles(20);
    chk("bounce_count", npulse, 2);
    chk("bounce_code", key_code, PLUS);
    chk("bounce_latency", tp[1] - m, 10);
    keys[10] = 1'b0;
    cycles(40);

    wait_col(3, "wait_col3_two");
    keys[13] = 1'b1;
    cycles(20);
    chk("enter_count", npulse, 3);
    chk("enter_code", key_code, ENTER);
    keys[0] = 1'b1;
    cycles(40);
    chk("two_ignored_count", npulse, 3);
    chk("two_ignored_code", key_code, ENTER);
    keys[13] = 1'b0;
    cycles(60);
    chk("k0_count", npulse, 4);
    chk("k0_code", key_code, 5'd0);
    keys[0] = 1'b0;
    cycles(40);

    wait_col(0, "wait_col0_rst");
    keys[5] = 1'b1;
    cycles(9);
    rst_n = 1'b0;
    #1;
    chk("midrst_col", col_out, 5'b11110);
    chk("midrst_code", key_code, NOP);
    chk("midrst_valid", key_valid, 0);
    cycles(1);
    rst_n = 1'b1;
    m = cyc;
    cycles(6);
    chk("midrst_no_pulse", npulse, 4);
    chk("midrst_col_after", col_out, 5'b11110);
    cycles(10);
    chk("midrst_repress_count", npulse, 5);
    chk("midrst_repress_code", key_code, 5'd5);
    chk("midrst_repress_latency", tp[4] - m, 12);
    keys[5] = 1'b0;
    cycles(40);

    wait_col(4, "wait_col4_up");
    keys[14] = 1'b1;
    m = cyc;
    cycles(115);
    keys[14] = 1'b0;
    cycles(40);
    chk("up_code", key_code, UP);
    chk("up_latency", tp[5] - m, 12);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("rep_count", npulse, 10);
    chk("rep_1", tp[6] - tp[5], 40);
    chk("rep_2", tp[7] - tp[5], 60);
    chk("rep_3", tp[8] - tp[5], 80);
    chk("rep_4", tp[9] - tp[5], 100);
`else
    chk("norep_count", npulse, 6);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
